// File: rtl/int_fu_pkg.sv
// Shared types and constants for the integer functional units.
// Covers ALU operation codes, shift kinds and shift-amount sources.
package int_fu_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int SHIFT_AMOUNT_BITS = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_AND    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_XOR    = 4'd6,
        ALU_PASS_B = 4'd7
    } alu_code_e;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_type_e;

    typedef enum logic {
        SHIFT_OPND_IMM = 1'b0,
        SHIFT_OPND_REG = 1'b1
    } shift_operand_e;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational barrel shifter (SLL/SRL/SRA/ROR) with carry-out.
// A zero shift amount passes the data through and forwards carry_in.
import int_fu_pkg::*;

module barrel_shifter #(
    parameter int WIDTH    = DATA_WIDTH,
    parameter int AMT_BITS = SHIFT_AMOUNT_BITS
) (
    input  logic [WIDTH-1:0]    data_in,
    input  logic [AMT_BITS-1:0] amount,
    input  logic [1:0]          shift_type,
    input  logic                carry_in,
    output logic [WIDTH-1:0]    data_out,
    output logic                carry_out
);

    // One guard bit on the side bits fall out of; it captures the last bit shifted out.
    logic [WIDTH:0]        sll_ext;
    logic [WIDTH:0]        srl_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0]      ror_val;

    assign sll_ext = {1'b0, data_in} << amount;
    assign srl_ext = {data_in, 1'b0} >> amount;
    assign sra_ext = $signed({data_in, 1'b0}) >>> amount;
    assign ror_val = (data_in >> amount) | (data_in << (WIDTH - int'(amount)));

    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        if (amount != '0) begin
            case (shift_type_e'(shift_type))
                SHIFT_SLL: {carry_out, data_out} = sll_ext;
                SHIFT_SRL: {data_out, carry_out} = srl_ext;
                SHIFT_SRA: {data_out, carry_out} = sra_ext;
                SHIFT_ROR: begin
                    data_out  = ror_val;
                    carry_out = ror_val[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/int_alu_shift_unit.sv
// Integer execution-stage unit: combinational ALU plus barrel shifter,
// a 2:1 result select and a single stallable output register.
import int_fu_pkg::*;

module int_alu_shift_unit #(
    parameter int DATA_WIDTH        = int_fu_pkg::DATA_WIDTH,
    parameter int SHIFT_AMOUNT_BITS = int_fu_pkg::SHIFT_AMOUNT_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         in_valid,
    input  logic                         op_sel,
    input  logic [3:0]                   alu_code,
    input  logic [DATA_WIDTH-1:0]        op_a,
    input  logic [DATA_WIDTH-1:0]        op_b,
    input  logic                         shift_operand_type,
    input  logic [1:0]                   shift_type,
    input  logic [SHIFT_AMOUNT_BITS-1:0] imm_shift_amount,
    input  logic                         carry_in,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         carry_out
);

    logic [DATA_WIDTH-1:0]        alu_result;
    logic [DATA_WIDTH-1:0]        shift_result;
    logic                         shift_carry;
    logic [SHIFT_AMOUNT_BITS-1:0] shift_amt;
    logic [DATA_WIDTH-1:0]        sel_result;
    logic                         sel_carry;

    always_comb begin
        alu_result = '0;
        case (alu_code_e'(alu_code))
            ALU_ADD:    alu_result = op_a + op_b;
            ALU_SUB:    alu_result = op_a - op_b;
            ALU_SLT:    alu_result = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU:   alu_result = DATA_WIDTH'(op_a < op_b);
            ALU_AND:    alu_result = op_a & op_b;
            ALU_OR:     alu_result = op_a | op_b;
            ALU_XOR:    alu_result = op_a ^ op_b;
            ALU_PASS_B: alu_result = op_b;
            default:    alu_result = '0;
        endcase
    end

    // Register-sourced amounts use only the low bits of op_b, like RV shift instructions.
    assign shift_amt = (shift_operand_e'(shift_operand_type) == SHIFT_OPND_REG)
                       ? op_b[SHIFT_AMOUNT_BITS-1:0] : imm_shift_amount;

    barrel_shifter #(
        .WIDTH    (DATA_WIDTH),
        .AMT_BITS (SHIFT_AMOUNT_BITS)
    ) u_shifter (
        .data_in    (op_a),
        .amount     (shift_amt),
        .shift_type (shift_type),
        .carry_in   (carry_in),
        .data_out   (shift_result),
        .carry_out  (shift_carry)
    );

    assign sel_result = op_sel ? shift_result : alu_result;
    assign sel_carry  = op_sel ? shift_carry : 1'b0;

    // Reset outranks stall; result/carry load even for invalid slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            result    <= sel_result;
            carry_out <= sel_carry;
        end
    end

endmodule

// File: tb/tb_int_alu_shift_unit.sv
// Self-checking bench for int_alu_shift_unit: directed cases plus
// randomized traffic compared against a bit-level behavioural model.
module tb_int_alu_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        in_valid;
    logic        op_sel;
    logic [3:0]  alu_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        shift_operand_type;
    logic [1:0]  shift_type;
    logic [4:0]  imm_shift_amount;
    logic        carry_in;
    logic        out_valid;
    logic [31:0] result;
    logic        carry_out;

    int assertCount = 0;
    int failCount   = 0;

    logic        expValid;
    logic [31:0] expResult;
    logic        expCarry;

    int_alu_shift_unit dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .in_valid           (in_valid),
        .op_sel             (op_sel),
        .alu_code           (alu_code),
        .op_a               (op_a),
        .op_b               (op_b),
        .shift_operand_type (shift_operand_type),
        .shift_type         (shift_type),
        .imm_shift_amount   (imm_shift_amount),
        .carry_in           (carry_in),
        .out_valid          (out_valid),
        .result             (result),
        .carry_out          (carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refAlu(logic [3:0] code, logic [31:0] a, logic [31:0] b);
        case (code)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: return (a < b) ? 32'd1 : 32'd0;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Returns {carry, data}; each output bit is picked individually from the source word.
    function automatic logic [32:0] refShift(logic [1:0] kind, logic [31:0] a, int amt, logic cin);
        logic [31:0] r;
        logic        c;
        if (amt == 0) return {cin, a};
        for (int i = 0; i < 32; i++) begin
            case (kind)
                2'd0: r[i] = (i >= amt) ? a[i-amt] : 1'b0;
                2'd1: r[i] = (i + amt < 32) ? a[i+amt] : 1'b0;
                2'd2: r[i] = (i + amt < 32) ? a[i+amt] : a[31];
                default: r[i] = a[(i+amt)%32];
            endcase
        end
        if (kind == 2'd0) c = a[32-amt];
        else if (kind == 2'd3) c = r[31];
        else c = a[amt-1];
        return {c, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advances one clock, updating the model from the inputs seen at the edge, then compares.
    task automatic stepCycle();
        logic [32:0] sh;
        int          amt;
        amt = shift_operand_type ? int'(op_b[4:0]) : int'(imm_shift_amount);
        sh  = refShift(shift_type, op_a, amt, carry_in);
        if (!rst) begin
            expValid  = 1'b0;
            expResult = 32'd0;
            expCarry  = 1'b0;
        end else if (!stall) begin
            expValid  = in_valid;
            expResult = op_sel ? sh[31:0] : refAlu(alu_code, op_a, op_b);
            expCarry  = op_sel ? sh[32] : 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
        checkOutput("result", result, expResult);
        checkOutput("carry_out", {31'd0, carry_out}, {31'd0, expCarry});
    endtask

    task automatic applyStimulus(input logic sel, input logic [3:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input logic opType, input logic [1:0] sType,
                                 input logic [4:0] imm, input logic cin, input logic valid);
        op_sel             = sel;
        alu_code           = code;
        op_a               = a;
        op_b               = b;
        shift_operand_type = opType;
        shift_type         = sType;
        imm_shift_amount   = imm;
        carry_in           = cin;
        in_valid           = valid;
        stepCycle();
    endtask

    task automatic applyRandom();
        applyStimulus(1'($urandom), 4'($urandom), $urandom, $urandom, 1'($urandom),
                      2'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd5, 32'd6, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd0, 32'd5, 32'd6, 1'b0, 2'd0, 5'd3, 1'b1, 1'b1);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b1;

        applyStimulus(1'b0, 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("add_wrap", result, 32'h0000_0001);
        checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("slt", result, 32'd1);
        applyStimulus(1'b0, 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("sltu", result, 32'd0);
        applyStimulus(1'b0, 4'd1, 32'd5, 32'd7, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("sub", result, 32'hFFFF_FFFE);

        applyStimulus(1'b1, 4'd0, 32'h8000_0001, 32'hFFFF_FF04, 1'b1, 2'd2, 5'd0, 1'b1, 1'b1);
        checkOutput("sra", result, 32'hF800_0000);
        checkOutput("sra_carry", {31'd0, carry_out}, 32'd0);
        applyStimulus(1'b1, 4'd0, 32'h8000_0001, 32'hFFFF_FF04, 1'b1, 2'd1, 5'd0, 1'b1, 1'b1);
        checkOutput("srl", result, 32'h0800_0000);
        applyStimulus(1'b1, 4'd0, 32'h8000_0001, 32'hFFFF_FF04, 1'b1, 2'd0, 5'd0, 1'b1, 1'b1);
        checkOutput("sll", result, 32'h0000_0010);
        applyStimulus(1'b1, 4'd0, 32'h8000_0001, 32'hFFFF_FF04, 1'b1, 2'd3, 5'd0, 1'b1, 1'b1);
        checkOutput("ror", result, 32'h1800_0000);
        checkOutput("ror_carry", {31'd0, carry_out}, 32'd0);

        applyStimulus(1'b1, 4'd0, 32'h0000_1234, 32'hFFFF_FF04, 1'b0, 2'd2, 5'd0, 1'b1, 1'b1);
        checkOutput("zero_shift", result, 32'h0000_1234);
        checkOutput("zero_shift_carry", {31'd0, carry_out}, 32'd1);
        applyStimulus(1'b1, 4'd0, 32'h8000_0000, 32'd0, 1'b0, 2'd0, 5'd1, 1'b0, 1'b1);
        checkOutput("sll1", result, 32'd0);
        checkOutput("sll1_carry", {31'd0, carry_out}, 32'd1);

        applyStimulus(1'b0, 4'd0, 32'd1, 32'd1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd6, $urandom, $urandom, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
            checkOutput("stall_result", result, 32'd2);
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        stall = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd3, 32'd4, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("unstall", result, 32'd7);

        rst   = 1'b0;
        stall = 1'b1;
        applyStimulus(1'b1, 4'd0, 32'h8000_0000, 32'd0, 1'b0, 2'd0, 5'd1, 1'b1, 1'b1);
        checkOutput("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_stall_result", result, 32'd0);
        checkOutput("rst_stall_carry", {31'd0, carry_out}, 32'd0);
        rst   = 1'b1;
        stall = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd10, 32'd20, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("post_reset", result, 32'd30);
        checkOutput("post_reset_valid", {31'd0, out_valid}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 31) != 0);
            stall = ($urandom_range(0, 7) == 0);
            applyRandom();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/int_alu_shift_unit.md
Name: int_alu_shift_unit

Overview:
- Single-lane integer functional unit for the integer back-end.
- Contains a combinational RISC-V-style ALU and a barrel shifter (SLL/SRL/SRA/ROR) with carry-out.
- A 2:1 result mux selects ALU or shifter output, followed by one output register stage.
- Sits at the integer execution stage; operands arrive already bypass-resolved.

Parameters:
DATA_WIDTH, 32, operand/result width
SHIFT_AMOUNT_BITS, 5, shift-amount width (log2 DATA_WIDTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (sampled at rising clk)
stall  in  1  hold all output registers when high
in_valid  in  1  operation valid this cycle
op_sel  in  1  0 = ALU result, 1 = shifter result
alu_code  in  4  ALU operation
op_a  in  DATA_WIDTH  operand A (ALU A / shifter data in)
op_b  in  DATA_WIDTH  operand B (ALU B; bits [4:0] = register shift amount)
shift_operand_type  in  1  0 = immediate amount, 1 = register amount
shift_type  in  2  0 SLL, 1 SRL, 2 SRA, 3 ROR
imm_shift_amount  in  SHIFT_AMOUNT_BITS  immediate shift amount
carry_in  in  1  carry used when effective shift amount is 0
out_valid  out  1  registered in_valid
result  out  DATA_WIDTH  registered selected result
carry_out  out  1  registered shifter carry (0 when op_sel=0)

Behaviour:
- ALU codes (combinational, modulo 2^32):
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 SLT: signed a<b → 1 else 0
  - 3 SLTU: unsigned compare → 1/0
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 PASS_B: b
  - 8–15: result 0
- Shift amount (amt):
  - amt = imm_shift_amount when shift_operand_type=0.
  - amt = op_b[4:0] when shift_operand_type=1; upper bits of op_b ignored.
- Shifter, amt>0:
  - SLL: a<<amt; carry = a[32−amt].
  - SRL: logical a>>amt; carry = a[amt−1].
  - SRA: arithmetic shift right, sign-filled; carry = a[amt−1].
  - ROR: rotate right; carry = result[31].
- Shifter, amt=0: result = a unchanged, carry = carry_in, for all shift types.
- Output mux: sel_result = op_sel ? shift_result : alu_result; sel_carry = op_sel ? shift_carry : 0.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Register update priority at each rising clk edge:
  - rst==0: out_valid←0, result←0, carry_out←0.
  - else stall==1: all outputs hold.
  - else: out_valid←in_valid, result←sel_result, carry_out←sel_carry.
- result and carry_out update even when in_valid=0; consumers qualify them with out_valid.
- Reset mid-stream discards the in-flight op; the first op after rst returns high appears one cycle later.
- Reset wins over a simultaneous stall.
- No X propagation from unused inputs; the output is fully determined by selected fields.
- Overflow is not flagged; ADD/SUB wrap.

Decomposition:
- Shared package int_fu_pkg:
  - ALU code enum (ADD..PASS_B).
  - Shift type enum (SLL, SRL, SRA, ROR).
  - Shift operand type enum (IMM, REG).
  - DATA_WIDTH and SHIFT_AMOUNT_BITS constants.
- One natural sub-module, barrel_shifter: purely combinational; data/amount/type/carry_in → data/carry_out.
- ALU and the output register stay in the top module.

Test Plan:
- ADD wrap: op_sel=0, alu_code=0, a=0xFFFFFFFF, b=2, in_valid=1 → next cycle result=0x00000001, out_valid=1, carry_out=0.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 → SLT result=1, SLTU result=0. SUB with a=5, b=7 → 0xFFFFFFFE.
- Shifts, op_sel=1, reg amount, op_b=0xFFFFFF04 (amt=4), a=0x80000001:
  - SRA → 0xF8000000, carry=0.
  - SRL → 0x08000000, carry=0.
  - SLL → 0x00000010, carry=0.
  - ROR → 0x18000000, carry=0.
- Zero shift and carry: imm amount 0, carry_in=1, a=0x1234 → result=0x1234, carry_out=1. SLL with imm amount 1, a=0x80000000 → result=0, carry_out=1.
- Stall hold: issue ADD 1+1, then raise stall and change inputs for 3 cycles → result stays 2, out_valid stays 1. Drop stall → new result next cycle.
- Reset: assert rst=0 together with stall=1 and a valid op → after edge out_valid=0, result=0, carry_out=0. Release rst → normal 1-cycle latency resumes.
